// File: rtl/tile_glyph_renderer.sv
// tile_glyph_renderer: renders one 2048 tile, value 2^exponent shown in decimal.
// Double-dabble converts the exponent; glyph rows come from an external font ROM.
module tile_glyph_renderer #(
    parameter int TILE_SIZE     = 106,
    parameter int GLYPH_W       = 16,
    parameter int GLYPH_H       = 46,
    parameter int TEXT_V_OFFSET = 30,
    parameter int EXP_W         = 5,
    parameter int MAX_EXP       = 16,
    parameter int MAX_DIGITS    = 5,
    parameter int ROM_LATENCY   = 1,
    parameter int FLASH_FRAMES  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [EXP_W-1:0]   exponent,
    output logic               busy,
    input  logic               flash_start,
    input  logic               frame_tick,
    input  logic [11:0]        h_cnt,
    input  logic [11:0]        v_cnt,
    output logic [3:0]         glyph_digit,
    output logic [5:0]         glyph_row,
    input  logic [GLYPH_W-1:0] glyph_bits,
    output logic [11:0]        vga_data
);

    localparam int COL_W = $clog2(GLYPH_W);
    localparam int SR_W  = MAX_EXP + 1;
    localparam int BCD_W = 4 * MAX_DIGITS;
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int IT_W  = $clog2(MAX_EXP + 1);
    localparam int FL_W  = $clog2(FLASH_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_SHIFT
    } state_t;

    state_t            state;
    logic [EXP_W-1:0]  pend_exp;
    logic [SR_W-1:0]   sr;
    logic [BCD_W-1:0]  bcd;
    logic [IT_W-1:0]   iter;

    logic [EXP_W-1:0]  disp_exp;
    logic [BCD_W-1:0]  disp_bcd;
    logic [CNT_W-1:0]  disp_cnt;
    logic [FL_W-1:0]   flash_cnt;

    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  bcd_nxt;
    logic [CNT_W-1:0]  cnt_nxt;

    logic [11:0]       text_w;
    logic [11:0]       h_start;
    logic [11:0]       rel;
    logic [11:0]       idx;
    logic [11:0]       sel;
    logic              in_v;
    logic              in_text;
    logic [3:0]        s0_dig;

    logic [COL_W-1:0]  s0_col;
    logic              s0_flag;
    logic [COL_W-1:0]  col_d [ROM_LATENCY];
    logic              flag_d [ROM_LATENCY];

    logic              bad_exp;
    logic [11:0]       bg_col;
    logic [11:0]       font_col;

    assign bad_exp = (exponent == '0) || (exponent > EXP_W'(MAX_EXP));

    // one double-dabble step: add 3 to digits >= 5, then shift in the next bit
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_nxt = {bcd_adj[BCD_W-2:0], sr[SR_W-1]};
        cnt_nxt = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (bcd_nxt[4*i +: 4] != 4'd0) begin
                cnt_nxt = CNT_W'(i + 1);
            end
        end
    end

    // conversion FSM; displayed value only changes on the final iteration
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            pend_exp <= '0;
            sr       <= '0;
            bcd      <= '0;
            iter     <= '0;
            disp_exp <= '0;
            disp_bcd <= '0;
            disp_cnt <= '0;
        end else if (load) begin
            if (bad_exp) begin
                state    <= ST_IDLE;
                busy     <= 1'b0;
                disp_exp <= exponent;
                disp_bcd <= '0;
                disp_cnt <= '0;
            end else begin
                state    <= ST_INIT;
                busy     <= 1'b1;
                pend_exp <= exponent;
            end
        end else begin
            case (state)
                ST_INIT: begin
                    sr    <= SR_W'(1) << pend_exp;
                    bcd   <= '0;
                    iter  <= '0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    sr   <= sr << 1;
                    bcd  <= bcd_nxt;
                    iter <= iter + IT_W'(1);
                    if (iter == IT_W'(MAX_EXP)) begin
                        disp_bcd <= bcd_nxt;
                        disp_cnt <= cnt_nxt;
                        disp_exp <= pend_exp;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // flash counter; a restart beats a simultaneous frame tick
    always_ff @(posedge clk) begin
        if (!rst) begin
            flash_cnt <= '0;
        end else if (flash_start) begin
            flash_cnt <= FL_W'(FLASH_FRAMES);
        end else if (frame_tick && flash_cnt != '0) begin
            flash_cnt <= flash_cnt - FL_W'(1);
        end
    end

    // centring and digit selection for the current pixel
    always_comb begin
        text_w  = 12'(disp_cnt) << COL_W;
        h_start = (12'(TILE_SIZE) - text_w) >> 1;
        rel     = h_cnt - h_start;
        idx     = rel >> COL_W;
        sel     = 12'(disp_cnt) - 12'd1 - idx;
        in_v    = (v_cnt >= 12'(TEXT_V_OFFSET)) &&
                  (v_cnt < 12'(TEXT_V_OFFSET + GLYPH_H));
        in_text = (h_cnt >= h_start) &&
                  (h_cnt < h_start + text_w) && in_v;
        s0_dig  = 4'hF;
        if (in_text) begin
            for (int i = 0; i < MAX_DIGITS; i++) begin
                if (sel == 12'(i)) begin
                    s0_dig = disp_bcd[4*i +: 4];
                end
            end
        end
    end

    // tile colours from the displayed exponent and flash state
    always_comb begin
        case (disp_exp)
            EXP_W'(0):  bg_col = 12'h000;
            EXP_W'(1):  bg_col = 12'hEED;
            EXP_W'(2):  bg_col = 12'hEEC;
            EXP_W'(3):  bg_col = 12'hFB7;
            EXP_W'(4):  bg_col = 12'hF96;
            EXP_W'(5):  bg_col = 12'hF75;
            EXP_W'(6):  bg_col = 12'hF53;
            EXP_W'(7):  bg_col = 12'hED7;
            EXP_W'(8):  bg_col = 12'hEC6;
            EXP_W'(9):  bg_col = 12'hEC5;
            EXP_W'(10): bg_col = 12'hEC3;
            EXP_W'(11): bg_col = 12'hEC2;
            default:    bg_col = 12'h333;
        endcase
        if (flash_cnt != '0) begin
            bg_col = 12'hFFF;
        end
        if (disp_exp == '0) begin
            font_col = 12'h000;
        end else if (disp_exp <= EXP_W'(2)) begin
            font_col = 12'h766;
        end else begin
            font_col = 12'hFFF;
        end
    end

    // S0: font ROM address plus column / in-text flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            glyph_digit <= 4'hF;
            glyph_row   <= '0;
            s0_col      <= '0;
            s0_flag     <= 1'b0;
        end else begin
            glyph_digit <= s0_dig;
            glyph_row   <= 6'(v_cnt - 12'(TEXT_V_OFFSET));
            s0_col      <= rel[COL_W-1:0];
            s0_flag     <= in_text;
        end
    end

    // delay column and flag to line up with the ROM data
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                col_d[i]  <= '0;
                flag_d[i] <= 1'b0;
            end
        end else begin
            col_d[0]  <= s0_col;
            flag_d[0] <= s0_flag;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                col_d[i]  <= col_d[i-1];
                flag_d[i] <= flag_d[i-1];
            end
        end
    end

    // final stage: pick font or background colour
    always_ff @(posedge clk) begin
        if (!rst) begin
            vga_data <= '0;
        end else if (flag_d[ROM_LATENCY-1]) begin
            vga_data <= glyph_bits[COL_W'(GLYPH_W - 1) - col_d[ROM_LATENCY-1]] ?
                        font_col : bg_col;
        end else begin
            vga_data <= bg_col;
        end
    end

endmodule

// File: tb/tb_tile_glyph_renderer.sv
// tb_tile_glyph_renderer: directed + random stimulus against a decimal model.
// Font ROM is emulated with a one-cycle hashed lookup.
module tb_tile_glyph_renderer;

    localparam int TS   = 106;
    localparam int GW   = 16;
    localparam int GH   = 46;
    localparam int TOFF = 30;
    localparam int MAXE = 16;
    localparam int FF   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [4:0]  exponent;
    logic        busy;
    logic        flash_start;
    logic        frame_tick;
    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic [3:0]  glyph_digit;
    logic [5:0]  glyph_row;
    logic [15:0] glyph_bits;
    logic [11:0] vga_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int dexp;
        int val;
        int cnt;
        bit fl;
    } snap_t;

    typedef struct {
        int    h;
        int    v;
        snap_t s;
        bit    r;
    } hist_t;

    hist_t hq[$];

    int m_dexp = 0;
    int m_val  = 0;
    int m_cnt  = 0;
    int m_fl   = 0;
    int m_busy = 0;
    int m_rem  = 0;
    int m_pend = 0;

    always #5 clk = ~clk;

    tile_glyph_renderer #(
        .TILE_SIZE(TS), .GLYPH_W(GW), .GLYPH_H(GH),
        .TEXT_V_OFFSET(TOFF), .EXP_W(5), .MAX_EXP(MAXE),
        .MAX_DIGITS(5), .ROM_LATENCY(1), .FLASH_FRAMES(FF)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .exponent(exponent),
        .busy(busy), .flash_start(flash_start), .frame_tick(frame_tick),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .glyph_digit(glyph_digit),
        .glyph_row(glyph_row), .glyph_bits(glyph_bits), .vga_data(vga_data)
    );

    function automatic logic [15:0] rom_f(input int d, input int r);
        logic [31:0] x;
        x = (32'(d) * 32'd40503) ^ (32'(r & 63) * 32'd2654435761) ^ 32'h5A5A1234;
        x = x ^ (x >> 13);
        return x[23:8];
    endfunction

    always @(posedge clk) glyph_bits <= rom_f(int'(glyph_digit), int'(glyph_row));

    function automatic int p10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int ndig(input int v);
        int n = 0;
        while (v > 0) begin
            n++;
            v = v / 10;
        end
        return n;
    endfunction

    function automatic int bg_of(input snap_t s);
        int tbl [12] = '{'h000, 'hEED, 'hEEC, 'hFB7, 'hF96, 'hF75,
                         'hF53, 'hED7, 'hEC6, 'hEC5, 'hEC3, 'hEC2};
        if (s.fl) return 'hFFF;
        if (s.dexp >= 12) return 'h333;
        return tbl[s.dexp];
    endfunction

    function automatic int font_of(input snap_t s);
        if (s.dexp == 0) return 'h000;
        if (s.dexp <= 2) return 'h766;
        return 'hFFF;
    endfunction

    // decimal digit under the pixel, or 15 when outside the text box
    function automatic int digit_at(input int h, input int v, input snap_t s);
        int tw = s.cnt * GW;
        int hs = (TS - tw) / 2;
        if (h >= hs && h < hs + tw && v >= TOFF && v < TOFF + GH)
            return (s.val / p10(s.cnt - 1 - (h - hs) / GW)) % 10;
        return 15;
    endfunction

    function automatic int pixel(input int h, input int v, input snap_t s);
        int d = digit_at(h, v, s);
        int hs = (TS - s.cnt * GW) / 2;
        logic [15:0] b;
        if (d == 15) return bg_of(s);
        b = rom_f(d, v - TOFF);
        return b[GW - 1 - ((h - hs) % GW)] ? font_of(s) : bg_of(s);
    endfunction

    function automatic bit same(input snap_t a, input snap_t b);
        return a.dexp == b.dexp && a.val == b.val && a.cnt == b.cnt && a.fl == b.fl;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic commit(input int e);
        m_dexp = e;
        if (e >= 1 && e <= MAXE) begin
            m_val = 1 << e;
            m_cnt = ndig(m_val);
        end else begin
            m_val = 0;
            m_cnt = 0;
        end
    endtask

    task automatic model_update();
        if (!rst) begin
            m_dexp = 0; m_val = 0; m_cnt = 0; m_fl = 0;
            m_busy = 0; m_rem = 0;
        end else begin
            if (load) begin
                if (exponent == 0 || exponent > MAXE) begin
                    commit(int'(exponent));
                    m_busy = 0;
                    m_rem  = 0;
                end else begin
                    m_pend = int'(exponent);
                    m_rem  = MAXE + 2;
                    m_busy = 1;
                end
            end else if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    commit(m_pend);
                    m_busy = 0;
                end
            end
            if (flash_start) m_fl = FF;
            else if (frame_tick && m_fl > 0) m_fl--;
        end
    endtask

    // one clock: model advance, then compare all outputs
    task automatic step();
        hist_t e;
        int    egd;
        int    egr;
        @(posedge clk);
        e.h  = int'(h_cnt);
        e.v  = int'(v_cnt);
        e.s  = '{dexp: m_dexp, val: m_val, cnt: m_cnt, fl: (m_fl != 0)};
        e.r  = !rst;
        hq.push_back(e);
        if (hq.size() > 3) void'(hq.pop_front());
        egd = e.r ? 15 : digit_at(e.h, e.v, e.s);
        egr = e.r ? 0 : ((e.v - TOFF) & 63);
        model_update();
        #1;
        chk("busy", int'(busy), m_busy);
        chk("glyph_digit", int'(glyph_digit), egd);
        chk("glyph_row", int'(glyph_row), egr);
        if (e.r) begin
            chk("vga_reset", int'(vga_data), 0);
        end else if (hq.size() == 3 && !hq[0].r && !hq[1].r &&
                     same(hq[0].s, hq[1].s) && same(hq[1].s, hq[2].s)) begin
            chk("vga", int'(vga_data), pixel(hq[0].h, hq[0].v, hq[0].s));
        end
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic busy_len(input string name);
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) n++;
            step();
        end
        chk(name, n, 18);
    endtask

    task automatic do_load(input int e);
        load = 1'b1;
        exponent = 5'(e);
        step();
        load = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    initial begin
        logic [15:0] b;
        int          saw;
        rst = 1'b0; load = 1'b0; exponent = '0;
        flash_start = 1'b0; frame_tick = 1'b0;
        h_cnt = '0; v_cnt = '0;
        wait_n(2);
        rst = 1'b1;

        // idle sweep after reset
        for (int i = 0; i < 20; i++) begin
            h_cnt = 12'($urandom_range(0, TS - 1));
            v_cnt = 12'($urandom_range(0, TS - 1));
            step();
        end
        chk("idle_vga", int'(vga_data), 'h000);
        chk("idle_busy", int'(busy), 0);
        chk("idle_digit", int'(glyph_digit), 'hF);

        // 2048
        h_cnt = '0; v_cnt = '0;
        do_load(11);
        busy_len("busy_len_11");
        h_cnt = 12'd21; v_cnt = 12'd30;
        step();
        chk("digit_2048_left", int'(glyph_digit), 2);
        wait_n(2);
        b = rom_f(2, 0);
        chk("pix_21_30", int'(vga_data), b[15] ? 'hFFF : 'hEC2);
        h_cnt = 12'd20;
        step();
        chk("digit_left_edge", int'(glyph_digit), 'hF);

        // 65536
        do_load(16);
        wait_n(20);
        h_cnt = 12'd12; v_cnt = 12'd40;
        wait_n(3);
        chk("bg_65536", int'(vga_data), 'h333);
        h_cnt = 12'd93;
        step();
        chk("digit_right_out", int'(glyph_digit), 'hF);
        h_cnt = 12'd13;
        step();
        chk("digit_65536_first", int'(glyph_digit), 6);
        h_cnt = 12'd92;
        step();
        chk("digit_65536_last", int'(glyph_digit), 6);

        // abort/restart
        h_cnt = '0; v_cnt = '0;
        do_load(1);
        wait_n(4);
        do_load(3);
        saw = 0;
        for (int i = 0; i < 40; i++) begin
            if (vga_data == 12'hEED) saw = 1;
            step();
        end
        chk("no_exp1_commit", saw, 0);
        chk("bg_after_restart", int'(vga_data), 'hFB7);
        do_load(1);
        wait_n(4);
        do_load(3);
        busy_len("busy_len_restart");

        // flash
        do_load(11);
        wait_n(20);
        flash_start = 1'b1;
        step();
        flash_start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        wait_n(2);
        chk("flash_7ticks", int'(vga_data), 'hFFF);
        flash_start = 1'b1; frame_tick = 1'b1;
        step();
        flash_start = 1'b0; frame_tick = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        wait_n(2);
        chk("flash_reload", int'(vga_data), 'hFFF);
        tick();
        wait_n(2);
        chk("flash_done", int'(vga_data), 'hEC2);

        // reset mid-conversion
        do_load(5);
        wait_n(6);
        rst = 1'b0;
        step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_vga", int'(vga_data), 0);
        rst = 1'b1;
        wait_n(20);
        chk("rst_exp0_vga", int'(vga_data), 'h000);
        chk("rst_no_commit", int'(busy), 0);

        // random phase
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 499) != 0);
            load        = ($urandom_range(0, 29) == 0);
            exponent    = 5'($urandom_range(0, 20));
            flash_start = ($urandom_range(0, 199) == 0);
            frame_tick  = ($urandom_range(0, 19) == 0);
            h_cnt       = 12'($urandom_range(0, TS - 1));
            v_cnt       = 12'($urandom_range(0, TS - 1));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tile_glyph_renderer.md
Name: tile_glyph_renderer

Overview:
Parametrised successor to the single-tile VGA renderer for the 2048 board. It renders one tile's pixel stream from tile-local h/v counters. Instead of a hard-coded digit table, it converts 2^exponent to decimal with a sequential double-dabble engine, so it supports any tile value up to 2^MAX_EXP. The digit string is centred horizontally, glyph rows are fetched from an external font ROM with configurable latency, and a frame-counted flash highlight is available for merge/spawn feedback.

Parameters:
TILE_SIZE, 106, tile width/height in pixels
GLYPH_W, 16, glyph width in pixels; must be a power of two
GLYPH_H, 46, glyph height in rows
TEXT_V_OFFSET, 30, first text row within the tile
EXP_W, 5, exponent input width
MAX_EXP, 16, largest renderable exponent (2^16 = 65536, 5 digits)
MAX_DIGITS, 5, decimal digit capacity
ROM_LATENCY, 1, font ROM cycles from address to glyph_bits
FLASH_FRAMES, 8, frames the flash highlight lasts

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous, active-low reset
load  in  1  one-cycle strobe; capture exponent and start conversion
exponent  in  EXP_W  tile exponent; 0 = empty tile
busy  out  1  conversion in progress
flash_start  in  1  start or restart the flash highlight
frame_tick  in  1  one-cycle pulse per video frame
h_cnt  in  12  tile-local column
v_cnt  in  12  tile-local row
glyph_digit  out  4  font ROM digit select; 4'hF = blank
glyph_row  out  6  font ROM row (v_cnt - TEXT_V_OFFSET)
glyph_bits  in  GLYPH_W  font ROM row data; MSB is the leftmost pixel
vga_data  out  12  RGB444 pixel

Behaviour:
- Reset, applied on a clk edge while rst=0, clears every register:
  - vga_data=0, busy=0, glyph_digit=4'hF, glyph_row=0
  - displayed exponent=0, displayed digits all 0, digit count=0, flash counter=0
  - pipeline valid flags cleared
  - reset during a conversion aborts it; no commit occurs.
- Conversion:
  - load=1 captures the exponent; busy=1 from the next cycle for exactly MAX_EXP+2 cycles (18 at default).
  - Sequence: one init cycle (value = 1<<exponent into a MAX_EXP+1-bit shift register, BCD cleared), then MAX_EXP+1 add-3/shift iterations. The final iteration commits the digits, the digit count and the displayed exponent atomically, and busy falls the cycle after.
  - Displayed digits stay stable (the old value) throughout a conversion.
  - load while busy aborts and restarts with the new exponent; busy stays high for a fresh MAX_EXP+2 cycles.
  - exponent=0 or exponent>MAX_EXP skips conversion: commit happens the next cycle, digit count=0, busy never rises.
- Digit count = position of the most significant non-zero BCD digit + 1.
- Centring:
  - text_w = count*GLYPH_W; h_start = (TILE_SIZE - text_w)>>1, floored.
  - Text region: h_start <= h_cnt < h_start+text_w and TEXT_V_OFFSET <= v_cnt < TEXT_V_OFFSET+GLYPH_H.
  - Digit index = (h_cnt-h_start)>>log2(GLYPH_W), leftmost digit first; column = low log2(GLYPH_W) bits.
- Pixel pipeline, with total latency ROM_LATENCY+2 cycles from h_cnt/v_cnt to vga_data:
  - S0 registers glyph_digit, glyph_row, column and the in-text flag; outside text, glyph_digit=4'hF.
  - The column and flag are delayed ROM_LATENCY cycles to align with glyph_bits.
  - The final stage registers vga_data = glyph_bits[GLYPH_W-1-col] ? font : bg when in text, else bg.
- Colours, indexed by displayed exponent:
  - bg: 0:000, 1:EED, 2:EEC, 3:FB7, 4:F96, 5:F75, 6:F53, 7:ED7, 8:EC6, 9:EC5, 10:EC3, 11:EC2, ≥12:333.
  - font: 0:000, 1–2:766, otherwise FFF.
  - Out-of-range exponent: bg 333, no text.
- Flash:
  - flash_start loads the counter with FLASH_FRAMES; each frame_tick decrements a non-zero counter.
  - If flash_start and frame_tick arrive in the same cycle, the reload wins.
  - While the counter is non-zero, bg is forced to FFF; font colour is unchanged.

Test Plan:
- Reset then idle with h_cnt/v_cnt sweeping -> vga_data=000 everywhere, busy=0, glyph_digit=F.
- load exponent=11 -> busy high 18 cycles; digits 2,0,4,8, count 4, h_start=21; pixel (21,30) shows glyph_digit=2 at S0 and vga_data FFF or EC2 per ROM bit, ROM_LATENCY+2 cycles later.
- load exponent=16 -> digits 6,5,5,3,6, count 5, h_start=13; h_cnt=12 -> bg 333; h_cnt=93 -> glyph_digit=F.
- load exponent=1, then load exponent=3 mid-conversion (cycle 5) -> busy continues 18 cycles from the second load; final digit 8, bg FB7, no intermediate "2" ever committed.
- flash_start with FLASH_FRAMES=8 -> bg FFF for 8 frame_ticks, then EC2; flash_start coincident with a frame_tick at count 1 -> counter reloads to 8.
- rst=0 asserted during a conversion -> next cycle busy=0, vga_data=000, displayed exponent 0.
